// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// The slave side is the adder; the master side is the producer/consumer pair.
interface pipe_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered chunks,
// with a stall-all valid/ready pipeline and signed-overflow detection.
module pipe_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pipe_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int FW    = (STAGES > 1) ? STAGES - 1 : 1;

  // Returns {carry_out, carry_into_chunk_msb, chunk_sum}.
  function automatic logic [CHUNK+1:0] add_chunk(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             c
  );
    logic [CHUNK:0] t;
    t = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
    return {t[CHUNK], a[CHUNK-1] ^ b[CHUNK-1] ^ t[CHUNK-1], t[CHUNK-1:0]};
  endfunction

  logic             advance_s;
  logic [WIDTH-1:0] opa_s  [STAGES];
  logic [WIDTH-1:0] opb_s  [STAGES];
  logic [WIDTH-1:0] psum_s [STAGES];
  logic [WIDTH-1:0] nsum_s [STAGES];
  logic             cin_s  [STAGES];
  logic             vin_s  [STAGES];
  logic [CHUNK+1:0] res_s  [STAGES];

  logic             v_r    [STAGES];
  logic             c_r    [STAGES];
  logic [WIDTH-1:0] sum_r  [STAGES];
  logic [WIDTH-1:0] a_r    [FW];
  logic [WIDTH-1:0] b_r    [FW];
  logic             ovf_r;

  assign advance_s     = ~v_r[STAGES-1] | bus.out_ready;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = v_r[STAGES-1];
  assign bus.Sum       = sum_r[STAGES-1];
  assign bus.Cout      = c_r[STAGES-1];
  assign bus.Ovf       = ovf_r;

  // Per-stage chunk arithmetic; operands and partial sums are kept right-aligned
  // so every stage always works on bits [CHUNK-1:0] and shifts its chunk in at the top.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        opa_s[k]  = bus.A;
        opb_s[k]  = bus.Sub ? ~bus.B : bus.B;
        cin_s[k]  = bus.Cin ^ bus.Sub;
        psum_s[k] = '0;
        vin_s[k]  = bus.in_valid & advance_s;
      end else begin
        opa_s[k]  = a_r[k-1];
        opb_s[k]  = b_r[k-1];
        cin_s[k]  = c_r[k-1];
        psum_s[k] = sum_r[k-1];
        vin_s[k]  = v_r[k-1];
      end
      res_s[k]  = add_chunk(opa_s[k][CHUNK-1:0], opb_s[k][CHUNK-1:0], cin_s[k]);
      nsum_s[k] = psum_s[k] >> CHUNK;
      nsum_s[k][WIDTH-1 -: CHUNK] = res_s[k][CHUNK-1:0];
    end
  end

  // Stage registers: the whole pipe advances together or holds together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= 1'b0;
        c_r[k]   <= 1'b0;
        sum_r[k] <= '0;
      end
      for (int k = 0; k < FW; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
      ovf_r <= 1'b0;
    end else if (advance_s) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= vin_s[k];
        c_r[k]   <= res_s[k][CHUNK+1];
        sum_r[k] <= nsum_s[k];
      end
      for (int k = 0; k < FW; k++) begin
        a_r[k] <= opa_s[k] >> CHUNK;
        b_r[k] <= opb_s[k] >> CHUNK;
      end
      ovf_r <= res_s[STAGES-1][CHUNK] ^ res_s[STAGES-1][CHUNK+1];
    end
  end
endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined adder/subtractor with valid/ready handshakes. It generalises the team's fixed 8-bit ripple adder to any width, splitting the carry chain into `STAGES` registered chunks so wide operands close timing. It adds a subtract mode, signed-overflow detection and backpressure. It sits between an operand producer and a result consumer in the ALU datapath and accepts one operation per cycle when not stalled.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be ≥ 1.
- `STAGES`, 2: pipeline depth and number of carry-chain chunks; must be ≥ 1 and must divide `WIDTH`. `CHUNK = WIDTH/STAGES`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept this cycle.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `Cin`  in  1  carry-in for add, borrow-in for subtract.
- `Sub`  in  1  0 = add, 1 = subtract.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result this cycle.
- `Sum`  out  WIDTH  result.
- `Cout`  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- `Ovf`  out  1  two's-complement signed overflow.

## Operation
- Add: `{Cout,Sum} = A + B + Cin`.
- Subtract: `B_eff = ~B`, `c0 = ~Cin`. `{Cout,Sum} = A + ~B + ~Cin`, which equals A − B − Cin modulo 2^WIDTH.
- `Ovf = carry_into_MSB XOR Cout`. This is identical in both modes.
- Chunk k (bits `[k*CHUNK +: CHUNK]`) is computed in stage k. Its carry-in is the registered carry out of stage k−1; stage 0 uses `c0`.
- Each stage register holds:
  - a valid bit,
  - the sum bits completed so far,
  - the unprocessed A and B_eff bits,
  - the inter-chunk carry,
  - for the last stage, the MSB carry-in needed for `Ovf`.
- `Sub` is folded into `B_eff` and `c0` at stage 0 and is not carried down the pipe.
- Stall-all pipeline:
  - `advance = ~out_valid | out_ready`.
  - `in_ready = advance`. This is combinational and does not depend on `in_valid`.
  - When `advance` = 1, every stage loads from its predecessor, and stage 0 loads the inputs with valid = `in_valid & in_ready`.
  - When `advance` = 0, all stages hold.
- Bubbles are not compressed. A stall freezes the whole pipe, including empty stages.
- `STAGES` = 1 degenerates to a single registered adder.
- Reset (asynchronous, at any time): all stage valid bits clear and all data registers clear. Any operations in flight are discarded and not reported.

## Timing
- Reset values: `out_valid` 0, `Sum` 0, `Cout` 0, `Ovf` 0, `in_ready` 1 (because `out_valid` is 0).
- Latency: an operation accepted at rising edge t appears with `out_valid` = 1 after edge t+STAGES−1. It is visible during the cycle following that edge, i.e. `STAGES` cycles after presentation.
- Throughput: one operation per cycle while `out_ready` = 1.
- Output stability: `Sum`, `Cout` and `Ovf` are registered. They are held stable while `out_valid` = 1 and `out_ready` = 0.
- Transfer rules:
  - Input transfer occurs on an edge where `in_valid` & `in_ready`.
  - Output transfer occurs on an edge where `out_valid` & `out_ready`.
  - A simultaneous output transfer and input acceptance in the same cycle is legal and loses no data.
- Ordering: results leave in acceptance order, with no drops or duplicates.
- Inputs need only be valid on the accepting edge.

## Test plan
- **Reset and basic add.** Reset, then WIDTH=8, STAGES=2, A=0x0F, B=0x0F, Cin=0, Sub=0 → after 2 cycles `Sum`=0x1E, `Cout`=0, `Ovf`=0. During reset all outputs are 0 and `in_ready`=1.
- **Carry and overflow edges.**
  - 0xFF+0x01, Cin=0 → `Sum` 0x00, `Cout` 1, `Ovf` 0.
  - 0x7F+0x00, Cin=1 → `Sum` 0x80, `Cout` 0, `Ovf` 1. This checks carry crossing the chunk boundary.
- **Subtract.**
  - 0x05−0x07, Cin=0 → `Sum` 0xFE, `Cout` 0, `Ovf` 0.
  - 0x80−0x01 → `Sum` 0x7F, `Cout` 1, `Ovf` 1.
  - 0x10−0x0F with Cin=1 → `Sum` 0x00, `Cout` 1.
- **Backpressure.** Stream 6 back-to-back adds (A=i, B=2i), holding `out_ready`=0 for 3 cycles mid-stream:
  - `in_ready` drops while stalled,
  - outputs are held stable,
  - all 6 results (3i) arrive in order, with no loss or duplication.
- **Reset mid-operation.** Accept 2 operations, then assert `rst` asynchronously between edges → `out_valid` falls immediately. No stale result appears after reset release, and the next accepted op returns the correct value.
- **Parameter sweep.** Run (WIDTH,STAGES) = (8,1), (16,4), (32,8) with 1000 random A/B/Cin/Sub values against a behavioural reference model → every `Sum`, `Cout` and `Ovf` matches. Latency equals `STAGES` when `out_ready`=1.
